// File: rtl/fifo_flags.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds,
// selectable registered or first-word-fall-through read, flush and sticky error flags.
module fifo_flags #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr_i,
    input  logic                          wren_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic                          rden_i,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          rvalid_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          afull_o,
    output logic                          aempty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          overflow_o,
    output logic                          underflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_nxt;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_ovf;
    logic                  r_unf;
    logic                  w_rd_acc;
    logic                  w_wr_acc;

    // A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
    always_comb begin
        w_rd_acc    = ~clr_i & rden_i & ~r_empty;
        w_wr_acc    = ~clr_i & wren_i & (~r_full | rden_i);
        w_count_nxt = r_count;
        if (clr_i) begin
            w_count_nxt = '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (clr_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
            if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
        end
    end

    // Flags are registered from the next count so they line up with count_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == CW'(FIFO_DEPTH));
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= CW'(AF_LEVEL));
            r_aempty <= (w_count_nxt <= CW'(AE_LEVEL));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (clr_i) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (wren_i && !w_wr_acc) r_ovf <= 1'b1;
            if (rden_i && !w_rd_acc) r_unf <= 1'b1;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is presented directly; gated to zero while empty.
            assign rdata_o  = r_empty ? '0 : r_mem[r_rptr];
            assign rvalid_o = ~r_empty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] r_rdata;
            logic                  r_rvalid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else if (clr_i) begin
                    r_rvalid <= 1'b0;
                end else if (w_rd_acc) begin
                    r_rdata  <= r_mem[r_rptr];
                    r_rvalid <= 1'b1;
                end else begin
                    r_rvalid <= 1'b0;
                end
            end

            assign rdata_o  = r_rdata;
            assign rvalid_o = r_rvalid;
        end
    endgenerate

    assign count_o     = r_count;
    assign full_o      = r_full;
    assign empty_o     = r_empty;
    assign afull_o     = r_afull;
    assign aempty_o    = r_aempty;
    assign overflow_o  = r_ovf;
    assign underflow_o = r_unf;

endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench for fifo_flags: one registered-read and one FWFT instance,
// each checked against a queue-based reference model after every clock edge.
module tb_fifo_flags;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          a_clr = 0, a_wren = 0, a_rden = 0;
    logic [DW-1:0] a_wdata = '0;
    logic [DW-1:0] a_rdata;
    logic          a_rvalid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf;
    logic [CW-1:0] a_count;

    logic          b_clr = 0, b_wren = 0, b_rden = 0;
    logic [DW-1:0] b_wdata = '0;
    logic [DW-1:0] b_rdata;
    logic          b_rvalid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
    logic [CW-1:0] b_count;

    fifo_flags #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .clr_i(a_clr), .wren_i(a_wren), .wdata_i(a_wdata),
        .rden_i(a_rden), .rdata_o(a_rdata), .rvalid_o(a_rvalid), .full_o(a_full),
        .empty_o(a_empty), .afull_o(a_afull), .aempty_o(a_aempty), .count_o(a_count),
        .overflow_o(a_ovf), .underflow_o(a_unf)
    );

    fifo_flags #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr_i(b_clr), .wren_i(b_wren), .wdata_i(b_wdata),
        .rden_i(b_rden), .rdata_o(b_rdata), .rvalid_o(b_rvalid), .full_o(b_full),
        .empty_o(b_empty), .afull_o(b_afull), .aempty_o(b_aempty), .count_o(b_count),
        .overflow_o(b_ovf), .underflow_o(b_unf)
    );

    int total = 0;
    int bad   = 0;

    // Reference models
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic          ov0 = 0, un0 = 0, rv0 = 0, ov1 = 0, un1 = 0;
    logic [DW-1:0] rd0 = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic [CW-1:0] cnt, input logic f, input logic e,
                              input logic af, input logic ae, input logic ov, input logic un,
                              input int mc, input logic mov, input logic mun);
        chk({tag, ".count"},  64'(cnt), 64'(mc));
        chk({tag, ".full"},   64'(f),   64'(mc == DEPTH));
        chk({tag, ".empty"},  64'(e),   64'(mc == 0));
        chk({tag, ".afull"},  64'(af),  64'(mc >= AF));
        chk({tag, ".aempty"}, 64'(ae),  64'(mc <= AE));
        chk({tag, ".ovf"},    64'(ov),  64'(mov));
        chk({tag, ".unf"},    64'(un),  64'(mun));
    endtask

    task automatic check0(input string tag);
        chk_status(tag, a_count, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf, q0.size(), ov0, un0);
        chk({tag, ".rvalid"}, 64'(a_rvalid), 64'(rv0));
        chk({tag, ".rdata"},  64'(a_rdata),  64'(rd0));
    endtask

    task automatic check1(input string tag);
        chk_status(tag, b_count, b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf, q1.size(), ov1, un1);
        chk({tag, ".rvalid"}, 64'(b_rvalid), 64'(q1.size() != 0));
        if (q1.size() != 0) chk({tag, ".rdata"}, 64'(b_rdata), 64'(q1[0]));
    endtask

    task automatic step0(input string tag, input logic wr, input logic [DW-1:0] wd, input logic rd, input logic clr);
        bit racc, wacc;
        a_wren = wr; a_wdata = wd; a_rden = rd; a_clr = clr;
        if (clr) begin
            q0.delete(); rv0 = 0; ov0 = 0; un0 = 0;
        end else begin
            racc = rd && (q0.size() != 0);
            wacc = wr && ((q0.size() != DEPTH) || rd);
            rv0 = racc;
            if (racc) rd0 = q0.pop_front();
            if (wacc) q0.push_back(wd);
            if (wr && !wacc) ov0 = 1;
            if (rd && !racc) un0 = 1;
        end
        @(posedge clk); #1;
        a_wren = 0; a_rden = 0; a_clr = 0;
        check0(tag);
    endtask

    task automatic step1(input string tag, input logic wr, input logic [DW-1:0] wd, input logic rd);
        bit racc, wacc;
        b_wren = wr; b_wdata = wd; b_rden = rd;
        racc = rd && (q1.size() != 0);
        wacc = wr && ((q1.size() != DEPTH) || rd);
        if (racc) void'(q1.pop_front());
        if (wacc) q1.push_back(wd);
        if (wr && !wacc) ov1 = 1;
        if (rd && !racc) un1 = 1;
        @(posedge clk); #1;
        b_wren = 0; b_rden = 0;
        check1(tag);
    endtask

    initial begin
        #2 rst_n = 0;
        #1;
        check0("rst_reg");
        check1("rst_fwft");
        chk("rst_fwft.rdata", 64'(b_rdata), 64'(0));
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // Fill to full
        for (int i = 0; i < DEPTH; i++) step0("fill", 1, DW'(i), 0, 0);
        // Overflow while full, then simultaneous write+read at full
        step0("ovf_wr", 1, 99, 0, 0);
        step0("full_wr_rd", 1, 100, 1, 0);
        chk("full_wr_rd.rdata0", 64'(a_rdata), 64'(0));
        // Drain: 1..7 then 100
        for (int i = 0; i < DEPTH; i++) step0("drain", 0, 0, 1, 0);
        chk("drain.last", 64'(a_rdata), 64'(100));
        // Read while empty
        step0("unf_rd", 0, 0, 1, 0);

        // FWFT instance
        step1("fwft_a5", 1, 32'hA5, 0);
        chk("fwft_a5.data", 64'(b_rdata), 64'h A5);
        step1("fwft_pop", 0, 0, 1);
        step1("fwft_w1", 1, 32'h11, 0);
        step1("fwft_w2", 1, 32'h22, 0);
        step1("fwft_w3", 1, 32'h33, 0);
        step1("fwft_wr_rd", 1, 32'h44, 1);
        for (int i = 0; i < 3; i++) step1("fwft_drain", 0, 0, 1);
        step1("fwft_unf", 0, 0, 1);
        step1("fwft_empty_wr_rd", 1, 32'h55, 1);

        // Flush with concurrent write, then async reset mid-cycle
        for (int i = 0; i < 5; i++) step0("pre_flush", 1, DW'(32'h200 + i), 0, 0);
        step0("flush", 1, 32'hDEAD, 0, 1);
        step0("post_flush_w", 1, 32'h300, 0, 0);
        step0("post_flush_w", 1, 32'h301, 0, 0);
        #2 rst_n = 0;
        #1;
        q0.delete(); rv0 = 0; rd0 = '0; ov0 = 0; un0 = 0;
        q1.delete(); ov1 = 0; un1 = 0;
        check0("async_rst_reg");
        check1("async_rst_fwft");
        #1 rst_n = 1;
        @(posedge clk); #1;
        check0("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
